fc_weight_psram_writer: RTL and testbench

Streams fully-connected layer weights and biases into PSRAM through the EF_PSRAM_CTRL_V2 command interface. It produces exactly the memory image the FC inference layer later reads back: row-major 16-bit weights at `weight_base_addr`, 16-bit biases at `bias_base_addr`. It sits between the host/boot loader word stream and the PSRAM controller, and is used once per model load before inference starts.

---
 rtl/fc_weight_psram_writer.sv | 145 ++++++++++++++
 tb/tb_fc_weight_psram_writer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_weight_psram_writer.sv
// Streams FC weights (paired into 32-bit writes) and per-row biases (16-bit writes)
// into PSRAM through the EF_PSRAM_CTRL_V2 command interface, once per model load.
module fc_weight_psram_writer #(
  parameter int INPUT_SIZE  = 320,
  parameter int OUTPUT_SIZE = 64,
  parameter int ACTIV_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [23:0]           weight_base_addr,
  input  logic [23:0]           bias_base_addr,
  input  logic [ACTIV_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [23:0]           psram_addr,
  output logic [31:0]           psram_data_i,
  output logic [2:0]            psram_size,
  output logic                  psram_start,
  output logic [7:0]            psram_cmd,
  output logic                  psram_rd_wr,
  output logic                  psram_qspi,
  output logic                  psram_qpi,
  output logic                  psram_short_cmd,
  input  logic                  psram_done,
  output logic                  busy,
  output logic                  load_done
);

  localparam int CW = $clog2(INPUT_SIZE + 1);
  localparam int RW = $clog2(OUTPUT_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_LO,
    GET_HI,
    WR_W,
    GET_B,
    WR_B,
    FIN
  } state_t;

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [23:0]           w_addr;
  logic [23:0]           b_addr;
  logic [ACTIV_BITS-1:0] lo_word;

  assign psram_cmd       = 8'h02;
  assign psram_rd_wr     = 1'b0;
  assign psram_qspi      = 1'b0;
  assign psram_qpi       = 1'b0;
  assign psram_short_cmd = 1'b0;

  // Running addresses advance when a write is issued, so the issued address is the pre-increment value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      w_addr       <= '0;
      b_addr       <= '0;
      lo_word      <= '0;
      in_ready     <= 1'b0;
      psram_addr   <= '0;
      psram_data_i <= '0;
      psram_size   <= '0;
      psram_start  <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            w_addr   <= weight_base_addr;
            b_addr   <= bias_base_addr;
            col      <= '0;
            row      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= GET_LO;
          end
        end
        GET_LO: begin
          if (in_valid) begin
            lo_word <= in_data;
            state   <= GET_HI;
          end
        end
        GET_HI: begin
          if (in_valid) begin
            psram_addr   <= w_addr;
            psram_data_i <= {in_data, lo_word};
            psram_size   <= 3'd4;
            psram_start  <= 1'b1;
            in_ready     <= 1'b0;
            w_addr       <= w_addr + 24'd4;
            state        <= WR_W;
          end
        end
        WR_W: begin
          if (psram_done) begin
            psram_start <= 1'b0;
            in_ready    <= 1'b1;
            col         <= col + CW'(2);
            state       <= (col == CW'(INPUT_SIZE - 2)) ? GET_B : GET_LO;
          end
        end
        GET_B: begin
          if (in_valid) begin
            psram_addr   <= b_addr;
            psram_data_i <= {{(32 - ACTIV_BITS){1'b0}}, in_data};
            psram_size   <= 3'd2;
            psram_start  <= 1'b1;
            in_ready     <= 1'b0;
            b_addr       <= b_addr + 24'd2;
            state        <= WR_B;
          end
        end
        WR_B: begin
          if (psram_done) begin
            psram_start <= 1'b0;
            col         <= '0;
            row         <= row + RW'(1);
            if (row == RW'(OUTPUT_SIZE - 1)) begin
              load_done <= 1'b1;
              state     <= FIN;
            end else begin
              in_ready <= 1'b1;
              state    <= GET_LO;
            end
          end
        end
        FIN: begin
          load_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_weight_psram_writer.sv
// Scoreboard bench for fc_weight_psram_writer: a PSRAM responder pops expected writes
// produced by a row/column address model of the weight and bias image.
module tb_fc_weight_psram_writer;

  localparam int IN  = 4;
  localparam int OUT = 2;
  localparam int NW  = OUT * (IN + 1);

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [23:0] weight_base_addr;
  logic [23:0] bias_base_addr;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] psram_addr;
  logic [31:0] psram_data_i;
  logic [2:0]  psram_size;
  logic        psram_start;
  logic [7:0]  psram_cmd;
  logic        psram_rd_wr;
  logic        psram_qspi;
  logic        psram_qpi;
  logic        psram_short_cmd;
  logic        psram_done;
  logic        busy;
  logic        load_done;

  txn_t        exp_q[$];
  logic [15:0] words[$];
  int          checks = 0;
  int          errors = 0;
  int          txn_count = 0;
  int          done_delay = 1;
  bit          abort = 1'b0;
  bit          stream_done = 1'b0;

  fc_weight_psram_writer #(
    .INPUT_SIZE (IN),
    .OUTPUT_SIZE(OUT),
    .ACTIV_BITS (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .weight_base_addr(weight_base_addr),
    .bias_base_addr  (bias_base_addr),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .psram_addr      (psram_addr),
    .psram_data_i    (psram_data_i),
    .psram_size      (psram_size),
    .psram_start     (psram_start),
    .psram_cmd       (psram_cmd),
    .psram_rd_wr     (psram_rd_wr),
    .psram_qspi      (psram_qspi),
    .psram_qpi       (psram_qpi),
    .psram_short_cmd (psram_short_cmd),
    .psram_done      (psram_done),
    .busy            (busy),
    .load_done       (load_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Expected image: weight pair at base + 2*(i*IN + j), bias at base + 2*i, all modulo 2^24.
  task automatic buildModel(input logic [23:0] wb, input logic [23:0] bb, input logic [15:0] w[$]);
    txn_t t;
    for (int i = 0; i < OUT; i++) begin
      for (int j = 0; j < IN; j += 2) begin
        t.a = wb + 24'(2 * (i * IN + j));
        t.d = {w[i * (IN + 1) + j + 1], w[i * (IN + 1) + j]};
        t.s = 3'd4;
        exp_q.push_back(t);
      end
      t.a = bb + 24'(2 * i);
      t.d = {16'h0000, w[i * (IN + 1) + IN]};
      t.s = 3'd2;
      exp_q.push_back(t);
    end
  endtask

  task automatic fillRandom();
    words.delete();
    for (int n = 0; n < NW; n++) words.push_back(16'($urandom));
  endtask

  task automatic streamWords(input logic [15:0] w[$], input int gap_pct);
    int wait_cyc;
    foreach (w[n]) begin
      if (abort) break;
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = w[n];
      wait_cyc = 0;
      while (!in_ready && !abort && wait_cyc < 2000) begin
        @(negedge clk);
        wait_cyc++;
      end
      if (abort) break;
      if (!in_ready) begin
        checkOutput("stream_stall", in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [23:0] wb, input logic [23:0] bb, input logic [15:0] w[$],
                               input int gap_pct, input bit noise);
    int cnt;
    int r;
    buildModel(wb, bb, w);
    @(negedge clk);
    weight_base_addr = wb;
    bias_base_addr   = bb;
    cfg_start        = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("ready_after_start", in_ready, 1);
    stream_done = 1'b0;
    fork
      begin
        streamWords(w, gap_pct);
        stream_done = 1'b1;
      end
      begin
        if (noise) begin
          for (int k = 0; k < 3; k++) begin
            r = $urandom_range(3, 15);
            for (int c = 0; c < r && !stream_done; c++) @(negedge clk);
            if (stream_done || !busy) break;
            weight_base_addr = 24'($urandom);
            bias_base_addr   = 24'($urandom);
            cfg_start        = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
          end
        end
      end
    join
    cnt = 0;
    while (!load_done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("load_done_pulse", load_done, 1);
    checkOutput("busy_in_fin", busy, 1);
    @(negedge clk);
    checkOutput("load_done_one_cycle", load_done, 0);
    checkOutput("busy_cleared", busy, 0);
    checkOutput("model_queue_drained", exp_q.size(), 0);
  endtask

  // PSRAM responder and scoreboard monitor: compares each new request, then holds done off.
  initial begin : responder
    txn_t got;
    txn_t e;
    int   dly;
    bit   stable;
    bit   aborted;
    psram_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && psram_start) begin
        txn_count++;
        got = {psram_addr, psram_data_i, psram_size};
        e   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checkOutput("txn", got, e);
        dly     = (done_delay > 0) ? done_delay : $urandom_range(1, 6);
        stable  = !in_ready;
        aborted = 1'b0;
        for (int k = 1; k < dly; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (!psram_start || in_ready || psram_addr != got.a || psram_data_i != got.d ||
              psram_size != got.s)
            stable = 1'b0;
        end
        if (!aborted) begin
          checkOutput("txn_hold", stable, 1);
          psram_done = 1'b1;
          @(negedge clk);
          psram_done = 1'b0;
          if (rst_n) checkOutput("start_drop_after_done", psram_start, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int cnt;
    int base_cnt;
    rst_n            = 1'b0;
    cfg_start        = 1'b0;
    weight_base_addr = '0;
    bias_base_addr   = '0;
    in_data          = 16'hA5A5;
    in_valid         = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_start", psram_start, 0);
    checkOutput("rst_addr", psram_addr, 0);
    checkOutput("rst_data", psram_data_i, 0);
    checkOutput("rst_size", psram_size, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("const_cmd", psram_cmd, 8'h02);
    checkOutput("const_flags", {psram_rd_wr, psram_qspi, psram_qpi, psram_short_cmd}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ready_after_release", in_ready, 0);
    checkOutput("idle_start_after_release", psram_start, 0);
    checkOutput("idle_busy_after_release", busy, 0);
    in_valid = 1'b0;

    $display("[TB] directed load");
    words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hB0B0,
              16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'hB1B1};
    done_delay = 1;
    applyStimulus(24'h001000, 24'h002000, words, 0, 1'b0);

    $display("[TB] 20-cycle done latency");
    fillRandom();
    done_delay = 20;
    applyStimulus(24'h0ABCD0, 24'h0FF000, words, 0, 1'b0);

    $display("[TB] random gaps with ignored cfg_start");
    for (int l = 0; l < 3; l++) begin
      fillRandom();
      done_delay = 0;
      applyStimulus(24'($urandom), 24'($urandom), words, 40, 1'b1);
    end

    $display("[TB] address wrap");
    fillRandom();
    done_delay = 1;
    applyStimulus(24'hFFFFFC, 24'hFFFFFE, words, 0, 1'b0);

    $display("[TB] reset during third transaction");
    fillRandom();
    done_delay = 4;
    base_cnt   = txn_count;
    buildModel(24'h003000, 24'h004000, words);
    @(negedge clk);
    weight_base_addr = 24'h003000;
    bias_base_addr   = 24'h004000;
    cfg_start        = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    fork
      streamWords(words, 0);
      begin
        cnt = 0;
        while (txn_count < base_cnt + 3 && cnt < 2000) begin
          @(negedge clk);
          cnt++;
        end
        checkOutput("third_txn_reached", txn_count - base_cnt, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        checkOutput("async_start_drop", psram_start, 0);
        checkOutput("async_busy_drop", busy, 0);
        checkOutput("async_ready_drop", in_ready, 0);
      end
    join
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    abort = 1'b0;
    @(negedge clk);
    fillRandom();
    done_delay = 0;
    applyStimulus(24'h005000, 24'h006000, words, 20, 1'b0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
